branch_redirect_unit: RTL

Consumes the branch-compare result produced in the ID stage (BEQ/BNE `eq`/`eqResult`) and turns it into fetch-side control for the MIPS pipeline. It selects the next PC, computes the branch target, and flushes or freezes IF/ID. It also stalls the branch while its compare operands are still in flight. It sits between the ID-stage comparator and the PC register/IF-ID pipeline register, and keeps resolution statistics for debug.

---
 rtl/branch_redirect_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: turns the ID-stage BEQ/BNE compare into next-PC select,
// PC / IF-ID enables, IF-ID flush and ID-EX bubble, and keeps branch statistics.
// Latency: control outputs are combinational (same-cycle resolve); counters,
// stall state and stallTimeout update at the edge ending the cycle.
// Backpressure: while a compare operand is in flight, PC and IF/ID are frozen
// and ID/EX receives a bubble until the operands are ready or the branch leaves ID.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   eq                 a BEQ/BNE instruction occupies ID this cycle
//   eqResult           branch condition true (valid when eq=1 and opndHazard=0)
//   opndHazard         branch source operand still being produced in EX/MEM
//   pcPlus4ID          PC+4 of the branch in ID
//   immSextID          sign-extended branch offset (in words)
//   pcPlus4IF          sequential next PC from fetch
//   nextPC             value to load into the PC
//   pcWrite            PC register enable
//   ifidWrite          IF/ID register enable
//   ifidFlush          clear IF/ID to NOP at the next edge
//   idexBubble         insert NOP into ID/EX at the next edge
//   brCount            resolved branches (wraps)
//   takenCount         resolved taken branches (wraps)
//   stallTimeout       sticky; set once a stall lasts STALL_MAX cycles
//
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot behaviour
// (the instruction after a taken branch is not flushed).

module branch_redirect_unit #(
  parameter int unsigned STALL_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eq,
  input  logic        eqResult,
  input  logic        opndHazard,
  input  logic [31:0] pcPlus4ID,
  input  logic [31:0] immSextID,
  input  logic [31:0] pcPlus4IF,
  output logic [31:0] nextPC,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexBubble,
  output logic [15:0] brCount,
  output logic [15:0] takenCount,
  output logic        stallTimeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [3:0] STALL_MAX_C = 4'(STALL_MAX);

  state_t      state_q, state_d;
  logic [3:0]  stall_cnt_q, stall_cnt_d;
  logic [15:0] br_count_q, taken_count_q;
  logic        timeout_q;

  logic        br_inc, taken_inc, timeout_set;
  logic [31:0] target;
  logic [3:0]  stall_next;

  // Offset is in words; bits shifted out of the top and the final carry are
  // intentionally dropped so the target wraps modulo 2^32.
  assign target = pcPlus4ID + (immSextID << 2);

  // First hazard cycle starts the count at 1; later ones saturate at 15 so a
  // very long stall can never wrap back below the timeout threshold.
  always_comb begin
    stall_next = 4'd1;
    if (state_q == STALL) begin
      stall_next = (stall_cnt_q == 4'd15) ? 4'd15 : stall_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      stall_cnt_q   <= 4'd0;
      br_count_q    <= 16'd0;
      taken_count_q <= 16'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      if (br_inc) begin
        br_count_q <= br_count_q + 16'd1;
      end
      if (taken_inc) begin
        taken_count_q <= taken_count_q + 16'd1;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    nextPC      = pcPlus4IF;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    br_inc      = 1'b0;
    taken_inc   = 1'b0;
    timeout_set = 1'b0;

    if (rst) begin
      // Reset wins over every input; a pending branch is simply abandoned.
      nextPC      = 32'd0;
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      state_d     = IDLE;
      stall_cnt_d = 4'd0;
    end else if (eq && !opndHazard) begin
      // Compare is valid: resolve now, whether or not we were stalling.
      br_inc      = 1'b1;
      state_d     = IDLE;
      stall_cnt_d = 4'd0;
      if (eqResult) begin
        nextPC    = target;
        taken_inc = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        ifidFlush = 1'b0;
`else
        ifidFlush = 1'b1;
`endif
      end
    end else if (eq) begin
      // Operands in flight: freeze fetch, bubble EX, eqResult is ignored.
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexBubble  = 1'b1;
      state_d     = STALL;
      stall_cnt_d = stall_next;
      if (stall_next >= STALL_MAX_C) begin
        timeout_set = 1'b1;
      end
    end else begin
      // No branch in ID; a stalled branch that vanished is dropped silently.
      state_d     = IDLE;
      stall_cnt_d = 4'd0;
    end
  end

  assign brCount      = br_count_q;
  assign takenCount   = taken_count_q;
  assign stallTimeout = timeout_q;

endmodule
